// File: rtl/obi_wb_arbiter_pkg.sv
// Shared types and constants for the OBI requester arbiter.
package obi_wb_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_REQ,
        ARB_WAIT
    } arb_state_e;

    // Read data returned to the requester when a transaction is aborted.
    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/obi_rr_pick.sv
// Combinational round-robin selector: the winner is the first requesting
// index above last_grant, wrapping from NUM_REQ-1 back to 0.
module obi_rr_pick #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [IDX_W-1:0]   winner,
    output logic               any_req
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    logic [IDX_W-1:0] idx;

    // Walk the ring once starting just after the last served index.
    // The wrap is an explicit compare so non-power-of-two counts work.
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        idx     = (last_grant == LAST_IDX) ? '0 : last_grant + 1'b1;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            if (!any_req && req[idx]) begin
                winner  = idx;
                any_req = 1'b1;
            end
            idx = (idx == LAST_IDX) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/obi_wb_arbiter.sv
// Round-robin arbiter sharing the OBI slave port of the OBI-to-Wishbone
// bridge between NUM_REQ requesters, one outstanding transaction at a time.
// Optional abort-on-timeout in ARB_WAIT: define OBI_WB_ARBITER_TIMEOUT_EN.
module obi_wb_arbiter
    import obi_wb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 3,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                        obi_clk_i,
    input  logic                        rst_ni,
    input  logic [NUM_REQ-1:0]          s_req_i,
    output logic [NUM_REQ-1:0]          s_gnt_o,
    input  logic [NUM_REQ*ADDR_W-1:0]   s_addr_i,
    input  logic [NUM_REQ-1:0]          s_wr_en_i,
    input  logic [NUM_REQ*DATA_W/8-1:0] s_byte_en_i,
    input  logic [NUM_REQ*DATA_W-1:0]   s_wdata_i,
    output logic [NUM_REQ-1:0]          s_rvalid_o,
    output logic [DATA_W-1:0]           s_rdata_o,
    output logic                        m_req_o,
    input  logic                        m_gnt_i,
    output logic [ADDR_W-1:0]           m_addr_o,
    output logic                        m_wr_en_o,
    output logic [DATA_W/8-1:0]         m_byte_en_o,
    output logic [DATA_W-1:0]           m_wdata_o,
    input  logic                        m_rvalid_i,
    input  logic [DATA_W-1:0]           m_rdata_i,
    output logic                        timeout_o
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned BE_W  = DATA_W / 8;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("obi_wb_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              wr_en;
        logic [BE_W-1:0]   byte_en;
        logic [DATA_W-1:0] wdata;
    } obi_req_t;

    arb_state_e                state_q, state_d;
    logic [IDX_W-1:0]          owner_q, last_grant_q, winner;
    logic                      any_req, load, done, abort, to_hit;
    obi_req_t [NUM_REQ-1:0]    req_arr;
    obi_req_t                  pay_q;
    logic [DATA_W-1:0]         rdata_q;

    // Regroup the flat requester buses into one request struct per port.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_arr[g] = '{
            addr:    s_addr_i[g*ADDR_W +: ADDR_W],
            wr_en:   s_wr_en_i[g],
            byte_en: s_byte_en_i[g*BE_W +: BE_W],
            wdata:   s_wdata_i[g*DATA_W +: DATA_W]
        };
    end

    obi_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req        (s_req_i),
        .last_grant (last_grant_q),
        .winner     (winner),
        .any_req    (any_req)
    );

`ifdef OBI_WB_ARBITER_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] to_cnt_q;
    logic             timeout_q;

    assign to_hit    = (state_q == ARB_WAIT) && (to_cnt_q == CNT_W'(TIMEOUT_CYCLES));
    assign timeout_o = timeout_q;

    // WAIT-cycle counter restarted on each grant; sticky abort flag.
    always_ff @(posedge obi_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state_q == ARB_REQ && m_gnt_i) begin
                to_cnt_q <= '0;
            end else if (state_q == ARB_WAIT && !to_hit) begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end
            if (abort) begin
                timeout_q <= 1'b1;
            end
        end
    end
`else
    assign to_hit    = 1'b0;
    assign timeout_o = 1'b0;
`endif

    // Next-state logic; a real response always beats a simultaneous timeout.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        done    = 1'b0;
        abort   = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (any_req) begin
                    load    = 1'b1;
                    state_d = ARB_REQ;
                end
            end
            ARB_REQ: begin
                if (m_gnt_i) begin
                    state_d = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                done  = m_rvalid_i;
                abort = !m_rvalid_i && to_hit;
                if (done || abort) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Grant and response are steered only to the current owner.
    always_comb begin
        s_gnt_o             = '0;
        s_rvalid_o          = '0;
        s_gnt_o[owner_q]    = (state_q == ARB_REQ) && m_gnt_i;
        s_rvalid_o[owner_q] = done || abort;
    end

    assign m_req_o     = (state_q != ARB_IDLE);
    assign m_addr_o    = pay_q.addr;
    assign m_wr_en_o   = pay_q.wr_en;
    assign m_byte_en_o = pay_q.byte_en;
    assign m_wdata_o   = pay_q.wdata;
    assign s_rdata_o   = rdata_q;

    // State, owner/payload latch at pick time, response data and rotation.
    always_ff @(posedge obi_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ARB_IDLE;
            owner_q      <= '0;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            pay_q        <= '0;
            rdata_q      <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                owner_q <= winner;
                pay_q   <= req_arr[winner];
            end
            if (done) begin
                rdata_q      <= m_rdata_i;
                last_grant_q <= owner_q;
            end else if (abort) begin
                rdata_q      <= DATA_W'(TIMEOUT_RDATA);
                last_grant_q <= owner_q;
            end
        end
    end

endmodule

// File: tb/tb_obi_wb_arbiter.sv
// Directed bench for obi_wb_arbiter: single write, round-robin rotation,
// read routing, payload latching, mid-transaction reset and (with
// OBI_WB_ARBITER_TIMEOUT_EN) the WAIT timeout abort.
module tb_obi_wb_arbiter;

    localparam int NR = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic              obi_clk_i = 1'b0;
    logic              rst_ni    = 1'b0;
    logic [NR-1:0]     s_req_i   = '0;
    logic [NR-1:0]     s_gnt_o;
    logic [NR*AW-1:0]  s_addr_i  = '0;
    logic [NR-1:0]     s_wr_en_i = '0;
    logic [NR*BW-1:0]  s_byte_en_i = '0;
    logic [NR*DW-1:0]  s_wdata_i = '0;
    logic [NR-1:0]     s_rvalid_o;
    logic [DW-1:0]     s_rdata_o;
    logic              m_req_o;
    logic              m_gnt_i   = 1'b0;
    logic [AW-1:0]     m_addr_o;
    logic              m_wr_en_o;
    logic [BW-1:0]     m_byte_en_o;
    logic [DW-1:0]     m_wdata_o;
    logic              m_rvalid_i = 1'b0;
    logic [DW-1:0]     m_rdata_i  = '0;
    logic              timeout_o;

    obi_wb_arbiter #(
        .NUM_REQ        (NR),
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .obi_clk_i   (obi_clk_i),
        .rst_ni      (rst_ni),
        .s_req_i     (s_req_i),
        .s_gnt_o     (s_gnt_o),
        .s_addr_i    (s_addr_i),
        .s_wr_en_i   (s_wr_en_i),
        .s_byte_en_i (s_byte_en_i),
        .s_wdata_i   (s_wdata_i),
        .s_rvalid_o  (s_rvalid_o),
        .s_rdata_o   (s_rdata_o),
        .m_req_o     (m_req_o),
        .m_gnt_i     (m_gnt_i),
        .m_addr_o    (m_addr_o),
        .m_wr_en_o   (m_wr_en_o),
        .m_byte_en_o (m_byte_en_o),
        .m_wdata_o   (m_wdata_o),
        .m_rvalid_i  (m_rvalid_i),
        .m_rdata_i   (m_rdata_i),
        .timeout_o   (timeout_o)
    );

    always #5 obi_clk_i = ~obi_clk_i;

    int n_chk = 0;
    int n_err = 0;

    logic [AW-1:0] p_addr [NR];
    logic          p_we   [NR];
    logic [BW-1:0] p_be   [NR];
    logic [DW-1:0] p_wd   [NR];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled around the falling edge.
    task automatic cyc();
        @(negedge obi_clk_i);
    endtask

    task automatic set_pay(input int i, input logic [AW-1:0] a, input logic we,
                           input logic [BW-1:0] be, input logic [DW-1:0] wd);
        p_addr[i] = a;
        p_we[i]   = we;
        p_be[i]   = be;
        p_wd[i]   = wd;
        s_addr_i[i*AW +: AW]    = a;
        s_wr_en_i[i]            = we;
        s_byte_en_i[i*BW +: BW] = be;
        s_wdata_i[i*DW +: DW]   = wd;
    endtask

    // Bridge model for one transaction: grant after gdly REQ cycles,
    // respond rdly cycles after the grant. drop clears all requests once
    // the grant is seen.
    task automatic serve(input int own, input int gdly, input int rdly,
                         input logic [DW-1:0] rd, input bit drop);
        logic [NR-1:0] oh;
        int k;
        oh = '0;
        oh[own] = 1'b1;
        k = 0;
        cyc(); #1;
        while (!m_req_o && k < 20) begin
            cyc(); #1;
            k++;
        end
        check("m_req_o_seen", m_req_o, 1);
        check("m_addr_o", m_addr_o, p_addr[own]);
        check("m_wr_en_o", m_wr_en_o, p_we[own]);
        check("m_byte_en_o", m_byte_en_o, p_be[own]);
        check("m_wdata_o", m_wdata_o, p_wd[own]);
        repeat (gdly) begin
            check("s_gnt_o_before_gnt", s_gnt_o, 0);
            cyc(); #1;
        end
        m_gnt_i = 1'b1;
        #1;
        check("s_gnt_o_owner", s_gnt_o, oh);
        check("s_rvalid_o_in_req", s_rvalid_o, 0);
        cyc();
        m_gnt_i = 1'b0;
        if (drop) s_req_i = '0;
        #1;
        repeat (rdly - 1) begin
            check("s_rvalid_o_wait", s_rvalid_o, 0);
            check("s_gnt_o_wait", s_gnt_o, 0);
            check("m_req_o_wait", m_req_o, 1);
            cyc(); #1;
        end
        m_rvalid_i = 1'b1;
        m_rdata_i  = rd;
        #1;
        check("s_rvalid_o_owner", s_rvalid_o, oh);
        cyc();
        m_rvalid_i = 1'b0;
        m_rdata_i  = 32'h5A5A_0000 ^ rd;
        #1;
        check("s_rvalid_o_after", s_rvalid_o, 0);
        check("m_req_o_after", m_req_o, 0);
        check("s_rdata_o", s_rdata_o, rd);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_m_req_o"}, m_req_o, 0);
        check({tag, "_s_gnt_o"}, s_gnt_o, 0);
        check({tag, "_s_rvalid_o"}, s_rvalid_o, 0);
        check({tag, "_s_rdata_o"}, s_rdata_o, 0);
        check({tag, "_m_addr_o"}, m_addr_o, 0);
        check({tag, "_m_wdata_o"}, m_wdata_o, 0);
        check({tag, "_m_be_we"}, {m_byte_en_o, m_wr_en_o}, 0);
        check({tag, "_timeout_o"}, timeout_o, 0);
    endtask

    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < NR; i++) set_pay(i, '0, 1'b0, '0, '0);

        // Reset state
        #3;
        check_reset_outputs("rst");
        cyc(); cyc();
        rst_ni = 1'b1;

        // Single write from requester 1
        set_pay(1, 32'h0000_1000, 1'b1, 4'hF, 32'h1234_5678);
        s_req_i = 3'b010;
        #1;
        check("pick_cycle_m_req_o", m_req_o, 0);
        check("pick_cycle_s_gnt_o", s_gnt_o, 0);
        serve(1, 2, 5, 32'h0000_0001, 1'b1);

        // All three requesting after reset: rotation 0,1,2,0,1,2
        cyc();
        rst_ni = 1'b0;
        cyc();
        rst_ni = 1'b1;
        for (int i = 0; i < NR; i++)
            set_pay(i, 32'h100 * (i + 1), i[0], 4'h1 << i, 32'hA000_0000 + i);
        s_req_i = 3'b111;
        for (int t = 0; t < 6; t++) serve(t % NR, 1, 2, 32'h0000_0100 + t, 1'b0);
        s_req_i = '0;
        cyc(); cyc();

        // Read for requester 2
        set_pay(2, 32'h0000_2000, 1'b0, 4'hF, 32'h0);
        s_req_i = 3'b100;
        serve(2, 1, 3, 32'hCAFE_F00D, 1'b1);

        // Payload change while in ARB_REQ is ignored
        set_pay(0, 32'h0000_3000, 1'b1, 4'h3, 32'h0BAD_0000);
        s_req_i = 3'b001;
        cyc();
        s_addr_i[0 +: AW] = 32'h0000_3FFC;
        #1;
        check("latched_addr", m_addr_o, 32'h0000_3000);
        serve(0, 1, 2, 32'h0000_0777, 1'b1);

        // Reset while in ARB_WAIT, then a stray response
        set_pay(1, 32'h0000_4000, 1'b1, 4'hF, 32'h4444_4444);
        s_req_i = 3'b010;
        cyc();
        m_gnt_i = 1'b1;
        cyc();
        m_gnt_i = 1'b0;
        s_req_i = '0;
        #1;
        check("wait_before_rst_m_req_o", m_req_o, 1);
        rst_ni = 1'b0;
        #1;
        check_reset_outputs("midrst");
        cyc(); cyc();
        rst_ni = 1'b1;
        cyc();
        m_rvalid_i = 1'b1;
        #1;
        check("stray_rvalid_s_rvalid_o", s_rvalid_o, 0);
        check("stray_rvalid_m_req_o", m_req_o, 0);
        cyc();
        m_rvalid_i = 1'b0;
        for (int i = 0; i < NR; i++)
            set_pay(i, 32'h5000 + 32'h10 * i, 1'b0, 4'hF, '0);
        s_req_i = 3'b111;
        serve(0, 1, 2, 32'h0000_5555, 1'b1);

`ifdef OBI_WB_ARBITER_TIMEOUT_EN
        // Bridge never responds: abort after 8 WAIT cycles
        set_pay(1, 32'h0000_6000, 1'b0, 4'hF, '0);
        s_req_i = 3'b010;
        cyc();
        m_gnt_i = 1'b1;
        #1;
        check("to_s_gnt_o", s_gnt_o, 3'b010);
        cyc();
        m_gnt_i = 1'b0;
        s_req_i = '0;
        #1;
        repeat (8) begin
            check("to_s_rvalid_o_wait", s_rvalid_o, 0);
            cyc(); #1;
        end
        check("to_s_rvalid_o_abort", s_rvalid_o, 3'b010);
        check("to_timeout_o_pre", timeout_o, 0);
        cyc(); #1;
        check("to_m_req_o", m_req_o, 0);
        check("to_s_rdata_o", s_rdata_o, 32'hDEAD_BEEF);
        check("to_timeout_o", timeout_o, 1);
        set_pay(2, 32'h0000_7000, 1'b1, 4'hF, 32'h7777_7777);
        s_req_i = 3'b100;
        serve(2, 1, 2, 32'h0000_7007, 1'b1);
        check("to_timeout_o_sticky", timeout_o, 1);
`else
        check("timeout_o_tied", timeout_o, 0);
`endif

        cyc();
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/obi_wb_arbiter.md
Name: obi_wb_arbiter

Overview:
- Shares the single OBI slave port of the OBI-to-Wishbone bridge between NUM_REQ OBI requesters, for example core instruction fetch, core data, and debug.
- Grants by round-robin and allows one outstanding transaction at a time.
- Routes the bridge's rvalid/rdata back to the requester that owns the transaction.
- Sits in the obi_clk_i domain, directly upstream of the bridge.

Parameters:
- NUM_REQ, 3, number of upstream OBI requesters (2..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT_CYCLES, 64, cycles allowed in WAIT before abort (used only with the optional feature).

Ports:
- obi_clk_i  in  1  OBI clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- s_req_i  in  NUM_REQ  per-requester request.
- s_gnt_o  out  NUM_REQ  per-requester grant.
- s_addr_i  in  NUM_REQ*ADDR_W  packed addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- s_wr_en_i  in  NUM_REQ  write enables.
- s_byte_en_i  in  NUM_REQ*DATA_W/8  packed byte enables.
- s_wdata_i  in  NUM_REQ*DATA_W  packed write data.
- s_rvalid_o  out  NUM_REQ  per-requester response valid.
- s_rdata_o  out  DATA_W  read data, broadcast to all requesters.
- m_req_o  out  1  request to bridge.
- m_gnt_i  in  1  bridge grant.
- m_addr_o  out  ADDR_W  address to bridge.
- m_wr_en_o  out  1  write enable to bridge.
- m_byte_en_o  out  DATA_W/8  byte enable to bridge.
- m_wdata_o  out  DATA_W  write data to bridge.
- m_rvalid_i  in  1  bridge response valid.
- m_rdata_i  in  DATA_W  bridge read data.
- timeout_o  out  1  sticky abort flag; tied 0 without the optional feature.

Behaviour:
- Reset values:
  - State ARB_IDLE; owner index 0; last_grant = NUM_REQ-1, so requester 0 wins first after reset.
  - All outputs 0; s_rdata_o 0.
- States:
  - ARB_IDLE:
    - If any s_req_i bit is high, pick the winner as the first set bit searching upward from last_grant+1 with wrap-around at NUM_REQ-1 to 0.
    - Latch the winner's index, addr, wr_en, byte_en and wdata into registers, then go to ARB_REQ.
    - No grant is issued in the cycle the winner is picked.
  - ARB_REQ:
    - m_req_o=1; m_* outputs driven from the latched registers.
    - s_gnt_o[owner] = m_gnt_i combinationally; all other s_gnt_o bits are 0.
    - On m_gnt_i, go to ARB_WAIT.
  - ARB_WAIT:
    - m_req_o stays 1, because the bridge samples its request until the response is delivered.
    - On m_rvalid_i: s_rvalid_o[owner]=1 combinationally, s_rdata_o registered from m_rdata_i, last_grant <= owner, m_req_o drops the next cycle, go to ARB_IDLE.
- Latency: minimum 1 cycle from s_req_i to m_req_o; s_rvalid_o appears in the same cycle as m_rvalid_i.
- Requester rules: a requester must hold s_req_i and its payload stable until it sees s_gnt_o. Payload changes after ARB_IDLE are ignored, because the payload is latched.
- Fairness: after a requester is served it has the lowest priority. With all requesters requesting, each is granted once per NUM_REQ transactions.
- Simultaneous events:
  - A request arriving in the cycle m_rvalid_i completes is not picked until the next ARB_IDLE cycle, giving 1 idle cycle between transactions.
  - m_rvalid_i in ARB_IDLE or ARB_REQ is ignored.
- A requester dropping s_req_i while in ARB_REQ does not cancel the transaction; completion still pulses s_rvalid_o to it.
- Reset mid-operation: all state clears asynchronously; any in-flight transaction is lost, with no response to any requester.
- Index width: IDX_W = $clog2(NUM_REQ); wrap uses an explicit compare against NUM_REQ-1 (NUM_REQ is not necessarily a power of 2).

Optional Feature:
- Macro: OBI_WB_ARBITER_TIMEOUT_EN.
- Defined:
  - A counter with width $clog2(TIMEOUT_CYCLES+1) is cleared on entry to ARB_WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES with no m_rvalid_i: s_rvalid_o[owner]=1, s_rdata_o=32'hDEAD_BEEF, m_req_o drops, timeout_o set sticky until reset, go to ARB_IDLE. last_grant updates as for a normal completion.
  - m_rvalid_i and the timeout in the same cycle: the real response wins and timeout_o is not set.
- Undefined: no counter; ARB_WAIT waits indefinitely; timeout_o is tied 0.

Decomposition:
- Package obi_wb_arbiter_pkg: arbiter state enum (ARB_IDLE, ARB_REQ, ARB_WAIT) and constant TIMEOUT_RDATA = 32'hDEAD_BEEF.
- Sub-module obi_rr_pick: purely combinational round-robin selector. Inputs: req vector and last_grant. Outputs: winner index and any_req.

Test Plan:
- Single requester 1, write addr 0x0000_1000, wdata 0x1234_5678, byte_en 0xF, with the bridge model granting after 2 cycles and rvalid after 5 cycles -> m_* carry those values, s_gnt_o=3'b010 for one cycle, s_rvalid_o=3'b010 in the m_rvalid_i cycle.
- All three requesters held high for 6 transactions -> grant order 0,1,2,0,1,2; no s_gnt_o bit other than the owner's ever high.
- Read: bridge returns m_rdata_i=0xCAFE_F00D for requester 2 -> s_rdata_o=0xCAFE_F00D, s_rvalid_o=3'b100; s_rvalid_o 0 in all other cycles.
- Requester 0 changes s_addr_i while in ARB_REQ -> m_addr_o keeps the latched address.
- Reset asserted in ARB_WAIT, then m_rvalid_i pulsed after reset release -> all outputs 0, no s_rvalid_o, next grant goes to requester 0.
- With OBI_WB_ARBITER_TIMEOUT_EN and TIMEOUT_CYCLES=8, bridge never responds -> s_rvalid_o[owner] after 8 WAIT cycles, s_rdata_o=0xDEAD_BEEF, timeout_o=1 and stays 1; next requester then served normally.
